edge_filter_pipe: RTL

//  Parametrised, fully registered pixel-filter pipeline between the display timing generator and
//  the VGA pins. Holds one line of history in an internal line buffer (no combinational row shift),

---
 rtl/edge_filter_pipe.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/edge_filter_pipe.sv
// Pixel filter: one-line buffer, 2x2 window, per-frame mode (pass/thr/Roberts/Roberts-thr/invert).
// Latency: 3 vga_clk cycles from pixel/sync inputs to outputs, every mode; hs/vs plain 3-stage delay.
// Backpressure: none; one pixel accepted on every pix_valid cycle.
module edge_filter_pipe #(
  parameter int   PIX_W     = 4,
  parameter int   LINE_W    = 640,
  parameter logic SYNC_IDLE = 1'b1
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic             sof,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic [2:0]       mode,
  input  logic [PIX_W-1:0] thr,
  output logic [PIX_W-1:0] vga_r,
  output logic [PIX_W-1:0] vga_g,
  output logic [PIX_W-1:0] vga_b,
  output logic             valid_out,
  output logic             hs_out,
  output logic             vs_out
);

  localparam int COL_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  // Row only feeds the row-0 boundary test, so a modest saturating width is enough.
  localparam int ROW_W = 11;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W - 1);

  // Position counters and frame-level shadow settings
  logic [COL_W-1:0] col_q, col_d, col_e;
  logic [ROW_W-1:0] row_q, row_d, row_e, row_inc;
  logic             pv_q;
  logic [2:0]       mode_s_q;
  logic [PIX_W-1:0] thr_s_q;

  // Line buffer (deliberately not reset)
  logic [PIX_W-1:0] line_mem [LINE_W];
  logic [PIX_W-1:0] up_rd;

  // Stage 1
  logic [PIX_W-1:0] cur1_q, up1_q;
  logic             bnd1_q, v1_q, bnd_d;

  // Stage 2
  logic [PIX_W-1:0] left_q, ul_q;
  logic [PIX_W-1:0] dx, dy;
  logic [PIX_W:0]   g_d, g2_q;
  logic [PIX_W-1:0] cur2_q;
  logic             v2_q;

  // Stage 3
  logic [PIX_W-1:0] y_d, y_q;
  logic             v3_q;
  logic [2:0]       hs_sr_q, vs_sr_q;

  // sof clears the position before the current pixel is placed, so a pixel arriving
  // with sof lands at row 0, col 0; wrap and short-line end both advance the row.
  always_comb begin
    col_e   = sof ? '0 : col_q;
    row_e   = sof ? '0 : row_q;
    row_inc = (row_e == '1) ? row_e : row_e + ROW_W'(1);
    col_d   = col_e;
    row_d   = row_e;
    if (pix_valid) begin
      if (col_e == COL_LAST) begin
        col_d = '0;
        row_d = row_inc;
      end else begin
        col_d = col_e + COL_W'(1);
      end
    end else if (pv_q && (col_e != '0)) begin
      col_d = '0;
      row_d = row_inc;
    end
  end

  // Counter, valid-history and shadow-register state
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q    <= '0;
      row_q    <= '0;
      pv_q     <= 1'b0;
      mode_s_q <= '0;
      thr_s_q  <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      pv_q  <= pix_valid;
      if (sof) begin
        mode_s_q <= mode;
        thr_s_q  <= thr;
      end
    end
  end

  // Read-before-write: the registered read below sees the word from the previous line.
  assign up_rd = line_mem[col_e];
  assign bnd_d = (row_e == '0) || (col_e == '0);

  // Line-buffer write of the incoming pixel
  always_ff @(posedge vga_clk) begin
    if (pix_valid) line_mem[col_e] <= pix_in;
  end

  // Roberts cross on the 2x2 window: a=up-left, b=up, c=left, d=current
  always_comb begin
    dx  = (ul_q >= cur1_q) ? (ul_q - cur1_q) : (cur1_q - ul_q);
    dy  = (up1_q >= left_q) ? (up1_q - left_q) : (left_q - up1_q);
    g_d = bnd1_q ? '0 : ({1'b0, dx} + {1'b0, dy});
  end

  // Output-value selection from the frame's shadowed mode; blank forces zero
  always_comb begin
    y_d = '0;
    if (v2_q) begin
      case (mode_s_q)
        3'd1:    y_d = (cur2_q > thr_s_q) ? {PIX_W{1'b1}} : '0;
        3'd2:    y_d = g2_q[PIX_W:1];
        3'd3:    y_d = (g2_q > {1'b0, thr_s_q}) ? {PIX_W{1'b1}} : '0;
        3'd4:    y_d = ~cur2_q;
        default: y_d = cur2_q;
      endcase
    end
  end

  // Three pipeline stages for pixel data, valid and syncs
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      cur1_q  <= '0;
      up1_q   <= '0;
      bnd1_q  <= 1'b0;
      v1_q    <= 1'b0;
      left_q  <= '0;
      ul_q    <= '0;
      g2_q    <= '0;
      cur2_q  <= '0;
      v2_q    <= 1'b0;
      y_q     <= '0;
      v3_q    <= 1'b0;
      hs_sr_q <= {3{SYNC_IDLE}};
      vs_sr_q <= {3{SYNC_IDLE}};
    end else begin
      cur1_q  <= pix_in;
      up1_q   <= up_rd;
      bnd1_q  <= bnd_d;
      v1_q    <= pix_valid;
      left_q  <= cur1_q;
      ul_q    <= up1_q;
      g2_q    <= g_d;
      cur2_q  <= cur1_q;
      v2_q    <= v1_q;
      y_q     <= y_d;
      v3_q    <= v2_q;
      hs_sr_q <= {hs_sr_q[1:0], hs_in};
      vs_sr_q <= {vs_sr_q[1:0], vs_in};
    end
  end

  assign vga_r     = y_q;
  assign vga_g     = y_q;
  assign vga_b     = y_q;
  assign valid_out = v3_q;
  assign hs_out    = hs_sr_q[2];
  assign vs_out    = vs_sr_q[2];

endmodule
